// File: rtl/motor_cmd_pkg.sv
// Shared types and helpers for the motor command UART.
// Build option MOTOR_CMD_PARITY_EN: when defined, each byte is framed 8E1 (11 bits)
// instead of 8N1 (10 bits).
package motor_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        NEXT,
        DONE
    } state_e;

    localparam logic [7:0] HEADER_DEFAULT = 8'hAA;

`ifdef MOTOR_CMD_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    function automatic logic [7:0] calc_chk(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2);
        return b0 ^ b1 ^ b2;
    endfunction

    function automatic int bit_cycles(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One-byte UART transmitter with a single holding slot.
// Build option MOTOR_CMD_PARITY_EN: inserts an even-parity bit after data bit 7.
// valid/ready: a byte is taken on any clock where valid && ready. ready is high when
// the line is idle, or during the stop bit while the holding slot is empty; a byte
// taken during the stop bit starts right as that stop bit ends, so consecutive
// bytes leave no idle gap. idle is high only when nothing is being shifted out.
module uart_tx_byte
    import motor_cmd_pkg::*;
#(
    parameter int BIT_CYCLES = 434
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       idle,
    output logic       tx
);
    localparam int CW = $clog2(BIT_CYCLES + 1);

    logic                  active_q, active_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [3:0]            bit_q, bit_d;
    logic [CW-1:0]         cyc_q, cyc_d;
    logic [7:0]            hold_q, hold_d;
    logic                  hold_v_q, hold_v_d;
    logic                  last_bit, bit_end, accept;

    // Frame is shifted out LSB first: start bit in bit 0, stop bit on top.
    function automatic logic [FRAME_BITS-1:0] frame_of(input logic [7:0] d);
`ifdef MOTOR_CMD_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    assign last_bit = (bit_q == 4'(FRAME_BITS - 1));
    assign bit_end  = (cyc_q == CW'(BIT_CYCLES - 1));
    assign ready    = !active_q || (last_bit && !hold_v_q);
    assign idle     = !active_q;
    assign accept   = valid && ready;
    assign tx       = frame_q[0];

    // Bit timing, frame shifting and the holding slot.
    always_comb begin
        active_d = active_q;
        frame_d  = frame_q;
        bit_d    = bit_q;
        cyc_d    = cyc_q;
        hold_d   = hold_q;
        hold_v_d = hold_v_q;
        if (!active_q) begin
            if (accept) begin
                frame_d  = frame_of(data);
                active_d = 1'b1;
                bit_d    = '0;
                cyc_d    = '0;
            end
        end else if (!bit_end) begin
            cyc_d = cyc_q + CW'(1);
        end else begin
            cyc_d = '0;
            if (!last_bit) begin
                bit_d   = bit_q + 4'd1;
                frame_d = {1'b1, frame_q[FRAME_BITS-1:1]};
            end else if (hold_v_q || accept) begin
                frame_d  = frame_of(hold_v_q ? hold_q : data);
                bit_d    = '0;
                hold_v_d = 1'b0;
            end else begin
                active_d = 1'b0;
                frame_d  = '1;
            end
        end
        if (active_q && accept && !(bit_end && last_bit)) begin
            hold_d   = data;
            hold_v_d = 1'b1;
        end
    end

    // Transmitter state registers; the line idles high.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            active_q <= 1'b0;
            frame_q  <= '1;
            bit_q    <= '0;
            cyc_q    <= '0;
            hold_q   <= '0;
            hold_v_q <= 1'b0;
        end else begin
            active_q <= active_d;
            frame_q  <= frame_d;
            bit_q    <= bit_d;
            cyc_q    <= cyc_d;
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
        end
    end

endmodule

// File: rtl/motor_cmd_uart.sv
// Serialises {direction, speed} into 4-byte packets: HEADER, dir, speed, XOR checksum.
// A packet is sent on any command change and at least every REFRESH_MS.
// Build option MOTOR_CMD_PARITY_EN: 8E1 framing in the byte transmitter.
module motor_cmd_uart
    import motor_cmd_pkg::*;
#(
    parameter int         CLK_FREQ   = 50_000_000,
    parameter int         BAUD       = 115200,
    parameter int         REFRESH_MS = 50,
    parameter logic [7:0] HEADER     = HEADER_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [2:0] direction,
    input  logic [2:0] speed,
    output logic       uart_out,
    output logic       busy,
    output logic [7:0] pkt_count
);
    localparam int BIT_CYCLES     = bit_cycles(CLK_FREQ, BAUD);
    localparam int REFRESH_CYCLES = CLK_FREQ / 1000 * REFRESH_MS;

    state_e      state_q, state_d;
    logic [5:0]  cmd_q, cmd_d, snap_q, snap_d;
    logic        pending_q, pending_d;
    logic        busy_q, busy_d;
    logic [31:0] timer_q, timer_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, tx_idle;
    logic        mismatch, refresh_hit, pending_now;

    assign cmd_d       = {direction, speed};
    assign mismatch    = (cmd_q != snap_q);
    assign refresh_hit = (timer_q == 32'(REFRESH_CYCLES - 1));
    assign pending_now = pending_q || mismatch || refresh_hit;
    assign busy        = busy_q;
    assign pkt_count   = cnt_q;

    // Byte for the current index, always built from the frozen snapshot.
    always_comb begin
        tx_data = HEADER;
        case (idx_q)
            2'd1:    tx_data = {5'b0, snap_q[5:3]};
            2'd2:    tx_data = {5'b0, snap_q[2:0]};
            2'd3:    tx_data = calc_chk(HEADER, {5'b0, snap_q[5:3]}, {5'b0, snap_q[2:0]});
            default: tx_data = HEADER;
        endcase
    end

    // Packet sequencer, pending flag and refresh timer. The timer is zero during
    // LOAD and counts every clock from there, so refresh packets start exactly
    // REFRESH_CYCLES apart.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        pending_d = pending_now;
        busy_d    = busy_q;
        timer_d   = timer_q + 32'd1;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        tx_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_now) begin
                    state_d = LOAD;
                    timer_d = '0;
                end
            end
            LOAD: begin
                snap_d    = cmd_q;
                pending_d = 1'b0;
                busy_d    = 1'b1;
                idx_d     = '0;
                state_d   = SEND;
            end
            SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) state_d = WAIT;
            end
            WAIT: begin
                if (idx_q == 2'd3) begin
                    if (tx_idle) state_d = DONE;
                end else if (tx_ready) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                idx_d   = idx_q + 2'd1;
                state_d = SEND;
            end
            DONE: begin
                cnt_d   = cnt_q + 8'd1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset leaves a packet pending so one goes out at once.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            snap_q    <= '0;
            pending_q <= 1'b1;
            busy_q    <= 1'b0;
            timer_q   <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            snap_q    <= snap_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
        end
    end

    uart_tx_byte #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_tx (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .data    (tx_data),
        .valid   (tx_valid),
        .ready   (tx_ready),
        .idle    (tx_idle),
        .tx      (uart_out)
    );

endmodule

// File: tb/tb_motor_cmd_uart.sv
// Self-checking bench for motor_cmd_uart, scaled to 4 clocks per bit and a
// 1000-clock refresh period.
module tb_motor_cmd_uart;
    localparam int CLK_FREQ   = 100_000;
    localparam int BAUD       = 25_000;
    localparam int REFRESH_MS = 10;
    localparam int BC         = CLK_FREQ / BAUD;
    localparam int R          = CLK_FREQ / 1000 * REFRESH_MS;
`ifdef MOTOR_CMD_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int PKT = 4 * FB * BC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] direction = '0;
    logic [2:0] speed = '0;
    logic       uart_out, busy;
    logic [7:0] pkt_count;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    typedef struct {
        logic [2:0]  dir;
        logic [2:0]  spd;
        logic [31:0] exp_pkt;
    } vec_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    motor_cmd_uart #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .REFRESH_MS(REFRESH_MS),
        .HEADER    (8'hAA)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .direction(direction),
        .speed    (speed),
        .uart_out (uart_out),
        .busy     (busy),
        .pkt_count(pkt_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for the line to go low; returns the cycle it was seen, or -1.
    task automatic wait_fall(input int budget, output int fc);
        int n;
        n = 0;
        while (uart_out !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        if (uart_out !== 1'b0) begin
            chk("start_timeout", 32'd0, 32'd1);
            fc = -1;
        end else begin
            fc = cyc;
        end
    endtask

    // Decodes one packet off the line, sampling mid-bit. If mid_dir >= 0 the
    // direction input is changed in the middle of byte 2.
    task automatic recv_pkt(input int budget, input int mid_dir, output logic [31:0] pkt,
                            output logic [3:0] par, output int f0);
        int         f[4];
        logic [7:0] b;
        pkt = '0;
        par = '0;
        f0  = -1;
        for (int k = 0; k < 4; k++) begin
            wait_fall(budget, f[k]);
            if (f[k] < 0) return;
            if (k == 0) begin
                f0 = f[k];
                chk("busy_in_pkt", 32'(busy), 32'd1);
            end else begin
                chk("byte_gap", 32'(f[k] - f[k-1]), 32'(FB * BC));
            end
            wait_to(f[k] + BC / 2);
            chk("start_bit", 32'(uart_out), 32'd0);
            for (int i = 0; i < 8; i++) begin
                wait_to(f[k] + (i + 1) * BC + BC / 2);
                b[i] = uart_out;
                if (k == 2 && i == 3 && mid_dir >= 0) direction = 3'(mid_dir);
            end
`ifdef MOTOR_CMD_PARITY_EN
            wait_to(f[k] + 9 * BC + BC / 2);
            par[k] = uart_out;
`endif
            wait_to(f[k] + (FB - 1) * BC + BC / 2);
            chk("stop_bit", 32'(uart_out), 32'd1);
            pkt = {pkt[23:0], b};
        end
    endtask

    // busy drops and the count steps two clocks after the last stop bit ends.
    task automatic end_pkt(input int f0, input int exp_cnt);
        wait_to(f0 + PKT + 1);
        chk("busy_tail", 32'(busy), 32'd1);
        tick();
        chk("busy_end", 32'(busy), 32'd0);
        chk("pkt_count", 32'(pkt_count), 32'(exp_cnt));
    endtask

    initial begin
        vec_t        vecs[4];
        logic [31:0] pkt;
        logic [3:0]  par;
        int          f0, c, prev_f, cnt;

        vecs[0] = '{3'd3, 3'd6, 32'hAA0306AF};
        vecs[1] = '{3'd7, 3'd7, 32'hAA0707AA};
        vecs[2] = '{3'd0, 3'd0, 32'hAA0000AA};
        vecs[3] = '{3'd1, 3'd2, 32'hAA0102A9};

        // Reset state
        direction = 3'd1;
        speed     = 3'd2;
        reset     = 1'b1;
        ticks(5);
        chk("reset_uart", 32'(uart_out), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_count", 32'(pkt_count), 32'd0);

        // First packet right after reset release
        reset = 1'b0;
        c = cyc;
        recv_pkt(50, -1, pkt, par, f0);
        chk("pkt_after_reset", pkt, 32'hAA0102A9);
        chk("first_start", 32'(f0), 32'(c + 3));
        end_pkt(f0, 1);
        cnt = 1;

        // Command changes while idle: payload and 3-clock latency
        for (int v = 0; v < 4; v++) begin
            ticks(10);
            direction = vecs[v].dir;
            speed     = vecs[v].spd;
            c = cyc;
            recv_pkt(50, -1, pkt, par, f0);
            chk("vec_pkt", pkt, vecs[v].exp_pkt);
            chk("vec_latency", 32'(f0), 32'(c + 4));
            cnt++;
            end_pkt(f0, cnt);
        end

        // Speed change, then direction change mid byte 2
        ticks(10);
        speed = 3'd5;
        c = cyc;
        recv_pkt(50, 4, pkt, par, f0);
        chk("old_cmd_pkt", pkt, 32'hAA0105AE);
        chk("chg_latency", 32'(f0), 32'(c + 4));
`ifdef MOTOR_CMD_PARITY_EN
        chk("parity_bits", 32'(par), 32'b1010);
`endif
        cnt++;
        end_pkt(f0, cnt);
        prev_f = f0;
        recv_pkt(50, -1, pkt, par, f0);
        chk("new_cmd_pkt", pkt, 32'hAA0405AB);
        chk("requeue_start", 32'(f0), 32'(prev_f + PKT + 5));
        cnt++;
        end_pkt(f0, cnt);

        // Periodic refresh with constant inputs
        for (int r = 0; r < 2; r++) begin
            prev_f = f0;
            recv_pkt(R + 50, -1, pkt, par, f0);
            chk("refresh_pkt", pkt, 32'hAA0405AB);
            chk("refresh_period", 32'(f0 - prev_f), 32'(R));
            cnt++;
            end_pkt(f0, cnt);
        end

        // Reset during byte 1
        ticks(10);
        direction = 3'd2;
        speed     = 3'd3;
        wait_fall(50, f0);
        if (f0 >= 0) begin
            wait_to(f0 + FB * BC + 1);
            chk("byte1_low", 32'(uart_out), 32'd0);
        end
        reset = 1'b1;
        tick();
        chk("rst_uart", 32'(uart_out), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(pkt_count), 32'd0);
        ticks(3);
        reset = 1'b0;
        c = cyc;
        recv_pkt(50, -1, pkt, par, f0);
        chk("post_rst_pkt", pkt, 32'hAA0203AB);
        chk("post_rst_start", 32'(f0), 32'(c + 3));
        end_pkt(f0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
